// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect controller for the 5-stage MIPS core.
// Detects load-use and HI/LO hazards, tracks the multi-cycle mult/div unit,
// and sequences exception entry / ERET return through a one-cycle REDIRECT
// state with EPC capture (delay-slot corrected).
// Optional macro PIPE_CTRL_BRANCH_HAZARD_EN adds a branch-operand stall for
// branches resolved in ID.
module pipe_hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_branch,
  input  logic        id_uses_hilo,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_memread,
  input  logic [4:0]  mem_wreg,
  input  logic        md_start,
  input  logic        imem_ready,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] mem_pc,
  input  logic        mem_bds,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic        md_busy
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

  localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [31:0] epc_q, epc_d;
  logic        sel_epc_q, sel_epc_d;  // 0: redirect to EXC_VECTOR, 1: to epc

  logic load_use_haz;
  logic hilo_haz;
  logic branch_haz;
  logic any_haz;
  logic busy;

  assign busy = (md_cnt_q != 6'd0);

  // Hazard detection: purely combinational, effective in the detection cycle.
  always_comb begin
    load_use_haz = ex_memread && (ex_wreg != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_wreg)) ||
                    (id_uses_rt && (id_rt == ex_wreg)));
    hilo_haz     = id_uses_hilo && (busy || md_start);
  end

`ifdef PIPE_CTRL_BRANCH_HAZARD_EN
  logic branch_ex_match;
  logic branch_mem_match;

  // Branch operands are compared in ID, so any in-flight producer must drain first.
  always_comb begin
    branch_ex_match  = ex_regwrite && (ex_wreg != 5'd0) &&
                       ((id_uses_rs && (id_rs == ex_wreg)) ||
                        (id_uses_rt && (id_rt == ex_wreg)));
    branch_mem_match = mem_memread && (mem_wreg != 5'd0) &&
                       ((id_uses_rs && (id_rs == mem_wreg)) ||
                        (id_uses_rt && (id_rt == mem_wreg)));
    branch_haz       = id_branch && (branch_ex_match || branch_mem_match);
  end
`else
  // Branches resolve in EX via forwarding; these inputs are intentionally idle.
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{id_branch, ex_regwrite, mem_memread, mem_wreg};
  assign branch_haz = 1'b0;
`endif

  assign any_haz = load_use_haz || hilo_haz || branch_haz;

  // Next-state and output decode; exception/ERET beats hazards, hazards beat imem wait.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    epc_d        = epc_q;
    sel_epc_d    = sel_epc_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = 32'd0;

    // mult/div counter runs independently of the redirect FSM
    if (md_start && !busy) begin
      md_cnt_d = MD_LOAD;
    end else if (busy) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end

    unique case (state_q)
      S_RUN: begin
        if (exc_req || eret_req) begin
          stall_pc     = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
          state_d      = S_REDIRECT;
          if (exc_req) begin
            epc_d     = mem_bds ? (mem_pc - 32'd4) : mem_pc;
            sel_epc_d = 1'b0;
          end else begin
            sel_epc_d = 1'b1;
          end
        end else if (any_haz) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (!imem_ready) begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
        end
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        flush_if_id = 1'b1;
        redirect_pc = sel_epc_q ? epc_q : EXC_VECTOR;
        state_d     = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // all controls are forced quiet while reset is held
    if (reset) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      flush_mem_wb = 1'b0;
      pc_redirect  = 1'b0;
      redirect_pc  = 32'd0;
    end
  end

  assign epc     = epc_q;
  assign md_busy = busy;

  // State registers: FSM, mult/div counter, EPC and redirect select.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q   <= S_RUN;
      md_cnt_q  <= 6'd0;
      epc_q     <= 32'd0;
      sel_epc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      epc_q     <= epc_d;
      sel_epc_q <= sel_epc_d;
    end
  end

endmodule
